// File: rtl/mm_arbiter_seq_if.sv
// mm_arbiter_seq_if: signal bundle between requesters, response sink and multiplier.
//   slave  : the arbiter side (consumes requests/done, drives grants/response/start).
//   master : the environment side (requesters, response sink, multiplier).
interface mm_arbiter_seq_if;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [127:0] req0_a;
  logic [127:0] req0_b;
  logic [127:0] req1_a;
  logic [127:0] req1_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [127:0] rsp_data;
  logic [31:0]  rsp_dot;
  logic         rsp_err;
  logic         busy;
  logic         mm_start;
  logic [255:0] mm_a;
  logic [255:0] mm_b;
  logic         mm_done;
  logic [255:0] mm_result;
  modport slave (
    input  req_valid, req0_a, req0_b, req1_a, req1_b, rsp_ready, mm_done, mm_result,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_dot, rsp_err, busy, mm_start, mm_a, mm_b
  );
  modport master (
    output req_valid, req0_a, req0_b, req1_a, req1_b, rsp_ready, mm_done, mm_result,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_dot, rsp_err, busy, mm_start, mm_a, mm_b
  );
endinterface

// File: rtl/mm_arbiter_seq.sv
// mm_arbiter_seq: round-robin sequencer sharing one 4-lane 32x32 multiplier between two requesters.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave side of mm_arbiter_seq_if (requests, response channel, multiplier start/done)
//   TIMEOUT    : WAIT cycles allowed before the transaction is answered with rsp_err
//   CNT_W      : width of the WAIT counter, must hold TIMEOUT-1
module mm_arbiter_seq #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 8
) (
  input logic             clk,
  input logic             rst_n,
  mm_arbiter_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t            state_q, state_d;
  logic [127:0]      a_q, a_d, b_q, b_d, data_q, data_d;
  logic [31:0]       dot_q, dot_d, lane_sum;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              id_q, id_d, last_q, last_d, err_q, err_d;
  logic              win, grant;
  // On a tie the requester that did not win last time goes; otherwise the lone valid one.
  assign win   = (&bus.req_valid) ? ~last_q : bus.req_valid[1];
  assign grant = (state_q == IDLE) && (|bus.req_valid);
  assign lane_sum = bus.mm_result[31:0] + bus.mm_result[63:32] + bus.mm_result[95:64] + bus.mm_result[127:96];
  assign bus.req_ready = grant ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_dot   = dot_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.mm_start  = (state_q == ISSUE);
  assign bus.mm_a      = {128'b0, a_q};
  assign bus.mm_b      = {128'b0, b_q};
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    dot_d   = dot_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (grant) begin
        a_d     = win ? bus.req1_a : bus.req0_a;
        b_d     = win ? bus.req1_b : bus.req0_b;
        id_d    = win;
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: if (bus.mm_done) begin
        data_d  = bus.mm_result[127:0];
        dot_d   = lane_sum;
        err_d   = 1'b0;
        state_d = RESP;
      end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        data_d  = '0;
        dot_d   = '0;
        err_d   = 1'b1;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RESP: if (bus.rsp_ready) begin
        last_d  = id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      dot_q   <= '0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      dot_q   <= dot_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_mm_arbiter_seq.sv
// tb_mm_arbiter_seq: self-checking bench for mm_arbiter_seq with a behavioural multiplier and reference model.
module tb_mm_arbiter_seq;
  localparam int TIMEOUT = 8;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  mm_arbiter_seq_if bus();
  mm_arbiter_seq #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int dly = 1;
  int cd = 0;
  logic stale = 1'b0;
  logic lg = 1'b1;
  logic [127:0] ra [2];
  logic [127:0] rb [2];
  logic [31:0]  last_dot;
  logic [127:0] last_data;
  function automatic logic [127:0] prod(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      longint p;
      p = longint'($signed(a[32*k +: 32])) * longint'($signed(b[32*k +: 32]));
      r[32*k +: 32] = p[31:0];
    end
    return r;
  endfunction
  function automatic logic [31:0] dsum(input logic [127:0] d);
    longint s;
    s = 0;
    for (int k = 0; k < 4; k++) s += longint'(d[32*k +: 32]);
    return s[31:0];
  endfunction
  function automatic logic [127:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  // Multiplier: done arrives in the dly-th WAIT cycle after start is sampled; dly=0 never answers.
  always @(posedge clk) begin
    if (bus.mm_start) begin
      n_start       <= n_start + 1;
      cd            <= dly;
      bus.mm_done   <= (dly == 1) || stale;
      bus.mm_result <= {$urandom(), $urandom(), $urandom(), $urandom(), prod(bus.mm_a[127:0], bus.mm_b[127:0])};
    end else begin
      if (cd > 1) cd <= cd - 1;
      bus.mm_done <= (cd == 2) || stale;
    end
  end
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    bus.req0_a = ra[0];
    bus.req0_b = rb[0];
    bus.req1_a = ra[1];
    bus.req1_b = rb[1];
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_id"}, bus.rsp_id, 0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 0);
    chk({tag, "_rsp_dot"}, bus.rsp_dot, 0);
    chk({tag, "_rsp_err"}, bus.rsp_err, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_mm_start"}, bus.mm_start, 0);
    chk({tag, "_mm_a"}, bus.mm_a, 0);
    chk({tag, "_mm_b"}, bus.mm_b, 0);
  endtask
  // Runs one transaction from the current requests; caller has set req_valid at a negedge.
  task automatic run_txn(input int bp, input bit keep);
    logic w;
    logic [127:0] ea, eb, ed;
    logic [31:0] edot;
    int n, s0, lat;
    bit err;
    #1;
    w    = (&bus.req_valid) ? ~lg : bus.req_valid[1];
    err  = (dly == 0) || (dly > TIMEOUT);
    lat  = err ? TIMEOUT + 1 : dly + 1;
    ea   = ra[w];
    eb   = rb[w];
    ed   = err ? '0 : prod(ea, eb);
    edot = err ? '0 : dsum(ed);
    s0   = n_start;
    chk("req_ready_grant", bus.req_ready, w ? 2'b10 : 2'b01);
    @(posedge clk);
    lg = w;
    @(negedge clk);
    if (keep) begin
      ra[w] = rnd();
      rb[w] = rnd();
      drive();
    end else bus.req_valid[w] = 1'b0;
    chk("busy", bus.busy, 1);
    chk("mm_start", bus.mm_start, 1);
    chk("mm_a", bus.mm_a, {128'b0, ea});
    chk("mm_b", bus.mm_b, {128'b0, eb});
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      chk("req_ready_busy", bus.req_ready, 0);
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("latency", n, lat);
    chk("rsp_id", bus.rsp_id, w);
    chk("rsp_err", bus.rsp_err, err);
    chk("rsp_data", bus.rsp_data, ed);
    chk("rsp_dot", bus.rsp_dot, edot);
    chk("start_once", n_start - s0, 1);
    last_dot  = bus.rsp_dot;
    last_data = bus.rsp_data;
    repeat (bp) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_id", bus.rsp_id, w);
      chk("bp_data", bus.rsp_data, ed);
      chk("bp_dot", bus.rsp_dot, edot);
      chk("bp_err", bus.rsp_err, err);
      chk("bp_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", bus.rsp_valid, 0);
    chk("start_total", n_start - s0, 1);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    ra[0] = '0; rb[0] = '0; ra[1] = '0; rb[1] = '0;
    drive();
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    // Contention from reset: grants must alternate starting with requester 0.
    ra[0] = rnd(); rb[0] = rnd(); ra[1] = rnd(); rb[1] = rnd();
    drive();
    bus.req_valid = 2'b11;
    repeat (4) run_txn(0, 1'b1);
    bus.req_valid = 2'b00;
    // Directed single request with mixed-sign lanes.
    ra[0] = {32'd1, 32'd7, 32'hFFFFFFFE, 32'd3};
    rb[0] = {32'd0, 32'hFFFFFFFF, 32'd5, 32'd4};
    drive();
    bus.req_valid = 2'b01;
    run_txn(0, 1'b0);
    chk("single_dot", last_dot, 32'hFFFFFFFB);
    chk("single_data", last_data, {32'd0, 32'hFFFFFFF9, 32'hFFFFFFF6, 32'd12});
    // Lane products and dot sum wrapping modulo 2^32.
    ra[1] = {4{32'h7FFFFFFF}};
    rb[1] = {4{32'd2}};
    drive();
    bus.req_valid = 2'b10;
    run_txn(0, 1'b0);
    chk("wrap_dot", last_dot, 32'hFFFFFFF8);
    chk("wrap_data", last_data, {4{32'hFFFFFFFE}});
    bus.req_valid = 2'b00;
    // Backpressure with both requesters pending.
    ra[0] = rnd(); rb[0] = rnd(); ra[1] = rnd(); rb[1] = rnd();
    drive();
    bus.req_valid = 2'b11;
    run_txn(5, 1'b1);
    bus.req_valid = 2'b00;
    // Timeout, done on the terminal count, done one cycle too late, then normal again.
    foreach (ra[i]) begin ra[i] = rnd(); rb[i] = rnd(); end
    drive();
    dly = 0;
    bus.req_valid = 2'b01;
    run_txn(0, 1'b0);
    dly = TIMEOUT;
    bus.req_valid = 2'b10;
    run_txn(0, 1'b0);
    dly = TIMEOUT + 1;
    bus.req_valid = 2'b01;
    run_txn(0, 1'b0);
    dly = 1;
    bus.req_valid = 2'b10;
    run_txn(0, 1'b0);
    // Reset while waiting, then a stale done that must be ignored.
    dly = 0;
    bus.req_valid = 2'b01;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    chk("midwait_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b1;
    @(negedge clk);
    stale = 1'b0;
    repeat (3) begin
      chk("stale_rsp_valid", bus.rsp_valid, 0);
      chk("stale_busy", bus.busy, 0);
      @(negedge clk);
    end
    lg = 1'b1;
    dly = 1;
    ra[0] = rnd(); rb[0] = rnd();
    drive();
    bus.req_valid = 2'b01;
    run_txn(0, 1'b0);
    bus.req_valid = 2'b00;
    // Randomized mix of requesters, multiplier delays and backpressure.
    repeat (30) begin
      ra[0] = rnd(); rb[0] = rnd(); ra[1] = rnd(); rb[1] = rnd();
      drive();
      dly = $urandom_range(0, TIMEOUT + 2);
      bus.req_valid = 2'($urandom_range(1, 3));
      run_txn($urandom_range(0, 3), 1'b0);
      bus.req_valid = 2'b00;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
